// File: rtl/gemvtile_instr_arbiter.sv
// gemvtile_instr_arbiter: round-robin arbiter sharing one gemvtile instruction port among NREQ requesters,
// with a one-entry holding register, busy-aware issue, sequence lock and lock timeout.
// Optional: define GEMVTILE_ARB_STATS_EN to add per-requester saturating issue counters (issue_count).
module gemvtile_instr_arbiter #(
    parameter int NREQ         = 4,
    parameter int INSTR_WIDTH  = 30,
    parameter int TOKEN_WIDTH  = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0][INSTR_WIDTH-1:0]    req_instr,
    input  logic [NREQ-1:0][TOKEN_WIDTH-1:0]    req_token,
    input  logic [NREQ-1:0]                     req_lock,
    output logic [INSTR_WIDTH-1:0]              instruction,
    output logic [TOKEN_WIDTH-1:0]              token_in,
    output logic                                inputValid,
    input  logic                                busy,
    output logic [$clog2(NREQ)-1:0]             grant_id,
    output logic                                locked,
`ifdef GEMVTILE_ARB_STATS_EN
    output logic [NREQ-1:0][15:0]               issue_count,
`endif
    output logic                                lock_timeout_pulse
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [GW-1:0]          ptr_q, grant_q, cand, idx;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [TOKEN_WIDTH-1:0] token_q;
    logic                   locked_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NREQ-1:0]        elig;
    logic                   found, idle, xfer, count_en, timeout;

    assign idle     = state_q == S_IDLE;
    assign elig     = locked_q ? (req_valid & (ONE << grant_q)) : req_valid;
    assign xfer     = idle & found;
    assign count_en = idle & locked_q & ~req_valid[grant_q] & (LOCK_TIMEOUT != 0);
    assign timeout  = count_en & (cnt_q == CW'(LOCK_TIMEOUT));
    assign cnt_d    = (count_en & ~timeout) ? cnt_q + 1'b1 : (idle ? '0 : cnt_q);
    assign state_d  = (state_q == S_ISSUE) ? (busy ? S_ISSUE : S_SETTLE) : (xfer ? S_ISSUE : S_IDLE);

    assign req_ready          = (xfer & ~rst) ? (ONE << cand) : '0;
    assign inputValid         = (state_q == S_ISSUE) & ~busy;
    assign instruction        = instr_q;
    assign token_in           = token_q;
    assign grant_id           = grant_q;
    assign locked             = locked_q;
    assign lock_timeout_pulse = timeout;

    // Pick the first eligible requester after the round-robin pointer, wrapping around
    always_comb begin
        cand  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(ptr_q) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    // FSM, holding register, grant/pointer and lock tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= GW'(NREQ - 1);
            grant_q  <= '0;
            instr_q  <= '0;
            token_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                instr_q  <= req_instr[cand];
                token_q  <= req_token[cand];
                grant_q  <= cand;
                ptr_q    <= cand;
                locked_q <= req_lock[cand];
            end else if (timeout) begin
                locked_q <= 1'b0;
            end
        end
    end

`ifdef GEMVTILE_ARB_STATS_EN
    logic [NREQ-1:0][15:0] stat_q;

    // Count issues per owner, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_q <= '0;
        else if (inputValid && stat_q[grant_q] != 16'hFFFF) stat_q[grant_q] <= stat_q[grant_q] + 16'd1;
    end

    assign issue_count = stat_q;
`endif
endmodule

// File: tb/tb_gemvtile_instr_arbiter.sv
// tb_gemvtile_instr_arbiter: directed scoreboard bench for gemvtile_instr_arbiter (LOCK_TIMEOUT=4)
module tb_gemvtile_instr_arbiter;
    typedef struct {
        logic [29:0] i;
        logic [15:0] t;
        logic        l;
    } item_t;

    typedef struct {
        logic [1:0]  g;
        logic [29:0] i;
        logic [15:0] t;
        logic        l;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0]           req_valid = '0;
    logic [3:0]           req_ready;
    logic [3:0][29:0]     req_instr = '0;
    logic [3:0][15:0]     req_token = '0;
    logic [3:0]           req_lock = '0;
    logic [29:0]          instruction;
    logic [15:0]          token_in;
    logic                 inputValid;
    logic                 busy = 1'b0;
    logic [1:0]           grant_id;
    logic                 locked;
    logic                 lock_timeout_pulse;
`ifdef GEMVTILE_ARB_STATS_EN
    logic [3:0][15:0]     issue_count;
`endif

    item_t rq[4][$];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_iss = -1;
    bit    gap_on = 1'b0;
    int    stat_exp[4] = '{0, 0, 0, 0};
    logic        s_iv, s_lock, s_pulse;
    logic [3:0]  s_rdy;
    logic [29:0] s_instr;
    logic [1:0]  s_grant;

    gemvtile_instr_arbiter #(
        .NREQ(4), .INSTR_WIDTH(30), .TOKEN_WIDTH(16), .LOCK_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_token(req_token), .req_lock(req_lock),
        .instruction(instruction), .token_in(token_in), .inputValid(inputValid), .busy(busy),
        .grant_id(grant_id), .locked(locked),
`ifdef GEMVTILE_ARB_STATS_EN
        .issue_count(issue_count),
`endif
        .lock_timeout_pulse(lock_timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = rq[i].size() != 0;
            req_instr[i] = rq[i].size() != 0 ? rq[i][0].i : '0;
            req_token[i] = rq[i].size() != 0 ? rq[i][0].t : '0;
            req_lock[i]  = rq[i].size() != 0 ? rq[i][0].l : 1'b0;
        end
    endtask

    task automatic enq(input int id, input int seq, input logic lk, input bit expect_issue);
        item_t it;
        exp_t  e;
        it.i = 30'(id * 256 + seq);
        it.t = 16'(16'hA000 + id * 16 + seq);
        it.l = lk;
        rq[id].push_back(it);
        if (expect_issue) begin
            e.g = 2'(id);
            e.i = it.i;
            e.t = it.t;
            e.l = lk;
            sb.push_back(e);
        end
        drive();
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_iv    = inputValid;
        s_rdy   = req_ready;
        s_instr = instruction;
        s_lock  = locked;
        s_pulse = lock_timeout_pulse;
        s_grant = grant_id;
        cyc++;
        if (s_iv) begin
            chk("sb_avail", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("issue_grant", 32'(grant_id), 32'(e.g));
                chk("issue_instr", 32'(instruction), 32'(e.i));
                chk("issue_token", 32'(token_in), 32'(e.t));
                chk("issue_locked", 32'(locked), 32'(e.l));
            end
            if (gap_on && last_iss >= 0) chk("rr_gap", 32'(cyc - last_iss), 3);
            last_iss = cyc;
            stat_exp[grant_id]++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (s_rdy[i] && rq[i].size() > 0) rq[i].delete(0);
        drive();
    endtask

    task automatic drain(input int max);
        for (int n = 0; n < max && sb.size() != 0; n++) tick();
        chk("drain_done", 32'(sb.size()), 0);
        tick();
    endtask

    initial begin
        drive();
        tick();
        chk("rst_iv", 32'(s_iv), 0);
        chk("rst_rdy", 32'(s_rdy), 0);
        chk("rst_lock", 32'(s_lock), 0);
        chk("rst_grant", 32'(s_grant), 0);
        chk("rst_instr", 32'(s_instr), 0);
        chk("rst_pulse", 32'(s_pulse), 0);
        rst = 1'b0;
        tick();

        // round robin with all four requesters valid
        enq(0, 1, 1'b0, 1'b1);
        enq(1, 1, 1'b0, 1'b1);
        enq(2, 1, 1'b0, 1'b1);
        enq(3, 1, 1'b0, 1'b1);
        enq(0, 2, 1'b0, 1'b1);
        gap_on = 1'b1;
        last_iss = -1;
        drain(40);
        gap_on = 1'b0;

        // busy stall on a held instruction from requester 1
        busy = 1'b1;
        enq(1, 5, 1'b0, 1'b1);
        tick();
        chk("stall_xfer_rdy", 32'(s_rdy), 32'b0010);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("stall_iv", 32'(s_iv), 0);
            chk("stall_rdy", 32'(s_rdy), 0);
            chk("stall_instr", 32'(s_instr), 32'(1 * 256 + 5));
        end
        busy = 1'b0;
        tick();
        chk("stall_release_iv", 32'(s_iv), 1);
        tick();
        chk("stall_settle_iv", 32'(s_iv), 0);
        chk("stall_sb_empty", 32'(sb.size()), 0);

        // locked sequence from requester 2 while 0 and 1 wait
        enq(2, 1, 1'b1, 1'b1);
        enq(2, 2, 1'b1, 1'b1);
        enq(2, 3, 1'b0, 1'b1);
        enq(0, 3, 1'b0, 1'b1);
        enq(1, 3, 1'b0, 1'b1);
        drain(60);

        // lock timeout: requester 3 locks and goes away, requester 0 waits
        enq(3, 7, 1'b1, 1'b1);
        enq(0, 7, 1'b0, 1'b1);
        tick();
        chk("to_xfer_rdy", 32'(s_rdy), 32'b1000);
        tick();
        chk("to_issue_iv", 32'(s_iv), 1);
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("to_idle_rdy", 32'(s_rdy), 0);
            chk("to_idle_pulse", 32'(s_pulse), 0);
            chk("to_idle_lock", 32'(s_lock), 1);
        end
        tick();
        chk("to_pulse", 32'(s_pulse), 1);
        chk("to_pulse_rdy", 32'(s_rdy), 0);
        tick();
        chk("to_after_pulse", 32'(s_pulse), 0);
        chk("to_after_lock", 32'(s_lock), 0);
        chk("to_after_rdy", 32'(s_rdy), 32'b0001);
        drain(20);

        // reset while an accepted instruction is held in ISSUE
        busy = 1'b1;
        enq(2, 9, 1'b1, 1'b0);
        tick();
        chk("rstmid_xfer_rdy", 32'(s_rdy), 32'b0100);
        tick();
        chk("rstmid_stall_lock", 32'(s_lock), 1);
        enq(0, 9, 1'b0, 1'b1);
        rst = 1'b1;
        stat_exp = '{0, 0, 0, 0};
        tick();
        chk("rstmid_iv", 32'(s_iv), 0);
        chk("rstmid_lock", 32'(s_lock), 0);
        chk("rstmid_grant", 32'(s_grant), 0);
        chk("rstmid_rdy", 32'(s_rdy), 0);
        chk("rstmid_instr", 32'(s_instr), 0);
        rst = 1'b0;
        busy = 1'b0;
        drain(20);

`ifdef GEMVTILE_ARB_STATS_EN
        for (int i = 0; i < 4; i++) chk("stats_count", 32'(issue_count[i]), 32'(stat_exp[i]));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
